// File: rtl/color_pkg.sv
// Shared types and code constants for the 2-bit color FSM command interface.
// Used by the driver, the out-code decoder and any color FSM instance.
package color_pkg;

    typedef enum logic {
        BLUE = 1'b0,
        RED  = 1'b1
    } color_state_e;

    localparam logic [1:0] OUT_BLUE  = 2'h1;
    localparam logic [1:0] OUT_RED   = 2'h2;
    localparam logic [1:0] IN_HOLD   = 2'h0;
    localparam logic [1:0] IN_TOGGLE = 2'h1;

    typedef enum logic [1:0] {
        ST_OK      = 2'h0,
        ST_TIMEOUT = 2'h1,
        ST_ILLEGAL = 2'h2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'h0,
        S_ISSUE = 2'h1,
        S_WAIT  = 2'h2,
        S_RESP  = 2'h3
    } drv_state_e;

    typedef struct packed {
        logic         legal;
        color_state_e color;
    } out_decode_t;

    // Counter width for a range of n values; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/color_fsm_driver_if.sv
// Request/response and FSM command signals between controller, driver and color FSM.
// master = driver side, slave = controller/FSM side.
interface color_fsm_driver_if #(
    parameter int unsigned RW = 2
);
    logic          req_valid;
    logic          req_ready;
    logic          req_color;
    logic [1:0]    fsm_in;
    logic [1:0]    fsm_out;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_status;
    logic [RW-1:0] resp_retries;
    logic          busy;

    modport master (
        input  req_valid, req_color, fsm_out, resp_ready,
        output req_ready, fsm_in, resp_valid, resp_status, resp_retries, busy
    );

    modport slave (
        output req_valid, req_color, fsm_out, resp_ready,
        input  req_ready, fsm_in, resp_valid, resp_status, resp_retries, busy
    );
endinterface

// File: rtl/color_out_decode.sv
// Decodes the color FSM out code into a legal flag and a Color_state.
module color_out_decode
    import color_pkg::*;
(
    input  logic [1:0]  code,
    output out_decode_t dec_c
);

    always_comb begin
        dec_c = '{legal: 1'b0, color: RED};
        case (code)
            OUT_BLUE: dec_c = '{legal: 1'b1, color: BLUE};
            OUT_RED:  dec_c = '{legal: 1'b1, color: RED};
            default:  dec_c = '{legal: 1'b0, color: RED};
        endcase
    end

endmodule

// File: rtl/color_fsm_driver.sv
// Initiator for the color FSM: toggles until the requested color is seen, retries, times out.
// Optional COLOR_DRV_STATS_EN adds a saturating toggle_count output.
module color_fsm_driver
    import color_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic               clk,
    input  logic               rst,
    color_fsm_driver_if.master bus
`ifdef COLOR_DRV_STATS_EN
    ,
    output logic [15:0]        toggle_count
`endif
);

    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned RW = cnt_width(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    drv_state_e   state_q, state_d;
    color_state_e target_q, target_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retries_q, retries_d;
    status_e      status_q, status_d;
    out_decode_t  dec_c;

    color_out_decode u_decode (
        .code  (bus.fsm_out),
        .dec_c (dec_c)
    );

    // Next-state and response bookkeeping
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        timer_d   = timer_q;
        retries_d = retries_q;
        status_d  = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    target_d  = color_state_e'(bus.req_color);
                    timer_d   = '0;
                    retries_d = '0;
                    if (!dec_c.legal) begin
                        status_d = ST_ILLEGAL;
                        state_d  = S_RESP;
                    end else if (dec_c.color == color_state_e'(bus.req_color)) begin
                        status_d = ST_OK;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dec_c.legal) begin
                    status_d = ST_ILLEGAL;
                    state_d  = S_RESP;
                end else if (dec_c.color == target_q) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    if (retries_q < RETRY_MAX) begin
                        retries_d = retries_q + RW'(1);
                        state_d   = S_ISSUE;
                    end else begin
                        status_d = ST_TIMEOUT;
                        state_d  = S_RESP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; outputs are registered copies derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            target_q         <= RED;
            timer_q          <= '0;
            retries_q        <= '0;
            status_q         <= ST_OK;
            bus.fsm_in       <= IN_HOLD;
            bus.req_ready    <= 1'b1;
            bus.busy         <= 1'b0;
            bus.resp_valid   <= 1'b0;
            bus.resp_status  <= ST_OK;
            bus.resp_retries <= '0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            timer_q          <= timer_d;
            retries_q        <= retries_d;
            status_q         <= status_d;
            bus.fsm_in       <= (state_d == S_ISSUE) ? IN_TOGGLE : IN_HOLD;
            bus.req_ready    <= (state_d == S_IDLE);
            bus.busy         <= (state_d != S_IDLE);
            bus.resp_valid   <= (state_d == S_RESP);
            bus.resp_status  <= status_d;
            bus.resp_retries <= retries_d;
        end
    end

`ifdef COLOR_DRV_STATS_EN
    // Cycles spent driving a toggle, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_count <= 16'h0000;
        end else if (bus.fsm_in == IN_TOGGLE && toggle_count != 16'hFFFF) begin
            toggle_count <= toggle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_color_fsm_driver.sv
// Directed bench: driver paired with a color FSM model (reset state Red).
module tb_color_fsm_driver;

    logic clk;
    logic rst;
    logic ignore_in;
    logic force_illegal;
    logic model_red;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   tog_q[$];
    int   lat;
    int   base;

    color_fsm_driver_if #(.RW(2)) bus ();

`ifdef COLOR_DRV_STATS_EN
    logic [15:0] toggle_count;
`endif

    color_fsm_driver #(
        .TIMEOUT_CYCLES (4),
        .MAX_RETRY      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef COLOR_DRV_STATS_EN
        ,
        .toggle_count (toggle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Color FSM model: toggles one cycle after seeing fsm_in=1
    always @(posedge clk) begin
        if (rst) model_red <= 1'b1;
        else if (!ignore_in && bus.fsm_in == 2'h1) model_red <= ~model_red;
    end
    assign bus.fsm_out = force_illegal ? 2'h3 : (model_red ? 2'h2 : 2'h1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.fsm_in == 2'h1) tog_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ignore_in     = 1'b0;
        force_illegal = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_color = 1'b0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_req(input logic color);
        bus.req_valid = 1'b1;
        bus.req_color = color;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Latency counted in cycles after the accepting edge; bounded
    task automatic wait_resp(output int n);
        n = 1;
        while (!bus.resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack_resp(input string tag);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, "_rv_after_ack"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_rdy_after_ack"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        do_reset();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_fsm_in", 32'(bus.fsm_in), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_status", 32'(bus.resp_status), 32'd0);
        check("rst_retries", 32'(bus.resp_retries), 32'd0);

        // Blue from Red: one toggle, OK after 3 cycles
        base = tog_q.size();
        send_req(1'b0);
        check("blue_fsm_in_issue", 32'(bus.fsm_in), 32'd1);
        check("blue_busy", 32'(bus.busy), 32'd1);
        check("blue_req_ready", 32'(bus.req_ready), 32'd0);
        wait_resp(lat);
        check("blue_latency", 32'(lat), 32'd3);
        check("blue_status", 32'(bus.resp_status), 32'd0);
        check("blue_retries", 32'(bus.resp_retries), 32'd0);
        check("blue_toggles", 32'(tog_q.size() - base), 32'd1);
`ifdef COLOR_DRV_STATS_EN
        check("blue_toggle_count", 32'(toggle_count), 32'd1);
`endif
        ack_resp("blue");

        // Red already matching: no toggle, OK after 1 cycle
        do_reset();
        base = tog_q.size();
        send_req(1'b1);
        wait_resp(lat);
        check("red_latency", 32'(lat), 32'd1);
        check("red_status", 32'(bus.resp_status), 32'd0);
        check("red_toggles", 32'(tog_q.size() - base), 32'd0);
`ifdef COLOR_DRV_STATS_EN
        check("red_toggle_count", 32'(toggle_count), 32'd0);
`endif
        ack_resp("red");

        // Unresponsive FSM: 3 toggles spaced 5 cycles, TIMEOUT with 2 retries
        do_reset();
        ignore_in = 1'b1;
        base = tog_q.size();
        send_req(1'b0);
        wait_resp(lat);
        check("to_latency", 32'(lat), 32'd16);
        check("to_status", 32'(bus.resp_status), 32'd1);
        check("to_retries", 32'(bus.resp_retries), 32'd2);
        check("to_toggles", 32'(tog_q.size() - base), 32'd3);
        if (tog_q.size() - base == 3) begin
            check("to_space1", 32'(tog_q[base+1] - tog_q[base]), 32'd5);
            check("to_space2", 32'(tog_q[base+2] - tog_q[base+1]), 32'd5);
        end
`ifdef COLOR_DRV_STATS_EN
        check("to_toggle_count", 32'(toggle_count), 32'd3);
`endif
        ack_resp("to");

        // Illegal code during WAIT, then hold the response for 5 cycles
        do_reset();
        send_req(1'b0);
        force_illegal = 1'b1;
        @(negedge clk);
        check("ill_fsm_in_wait", 32'(bus.fsm_in), 32'd0);
        @(negedge clk);
        check("ill_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("ill_status", 32'(bus.resp_status), 32'd2);
        check("ill_fsm_in", 32'(bus.fsm_in), 32'd0);
        force_illegal = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_color = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_status", 32'(bus.resp_status), 32'd2);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        ack_resp("hold");

        // Illegal code already present at request time
        force_illegal = 1'b1;
        base = tog_q.size();
        send_req(1'b1);
        wait_resp(lat);
        check("ill_idle_latency", 32'(lat), 32'd1);
        check("ill_idle_status", 32'(bus.resp_status), 32'd2);
        check("ill_idle_toggles", 32'(tog_q.size() - base), 32'd0);
        force_illegal = 1'b0;
        ack_resp("ill_idle");

        // Reset while waiting discards the request
        do_reset();
        ignore_in = 1'b1;
        send_req(1'b0);
        @(negedge clk);
        check("wrst_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("wrst_busy", 32'(bus.busy), 32'd0);
        check("wrst_fsm_in", 32'(bus.fsm_in), 32'd0);
        check("wrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("wrst_req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
